lfsr_stream_decrypt: RTL and testbench

- Parametrised streaming successor to the program 2/3 decrypt flow.
- Accepts MSG_LEN encrypted bytes on a valid/ready input, then:
  - recovers the LFSR seed and tap pattern from the known space preamble;
  - decrypts each byte and checks parity;
  - strips all leading spaces;
  - emits exactly MSG_LEN output bytes, flagging corrupt ones.
- Sits between data-memory reader and writer inside top_level; controlled by req/ack.

---
 rtl/lfsr_pkg.sv | 31 +++
 rtl/lfsr_step.sv | 38 +++
 rtl/lfsr_stream_decrypt.sv | 189 ++++++++++++++++++
 tb/tb_lfsr_stream_decrypt.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types, tap table and LFSR step rule for the streaming decrypter.
// One tap pattern per candidate; bit 6 of each state is the oldest bit.
package lfsr_pkg;

   localparam int LFSR_W = 7;
   localparam int PTRN_N = 9;

   // Index 0 is the last element of the concatenation.
   localparam logic [PTRN_N-1:0][LFSR_W-1:0] PTRN = {
      7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A,
      7'h72, 7'h78, 7'h48, 7'h60
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEED,
      ST_SEARCH,
      ST_STRIP,
      ST_PASS,
      ST_FILL,
      ST_DONE
   } state_e;

   function automatic logic [LFSR_W-1:0] lfsr_next(
      input logic [LFSR_W-1:0] s,
      input logic [LFSR_W-1:0] taps
   );
      return {s[LFSR_W-2:0], ^(s & taps)};
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// One candidate LFSR: loads a seed, then advances once per enable.
// next_o is the state that will key the next accepted byte.
module lfsr_step
   import lfsr_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic              en_i,
   input  logic [LFSR_W-1:0] seed_i,
   input  logic [LFSR_W-1:0] taps_i,
   output logic [LFSR_W-1:0] next_o
);

   logic [LFSR_W-1:0] state_q, state_d;

   assign next_o = lfsr_next(state_q, taps_i);

   // Seed load has priority over stepping
   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = seed_i;
      end else if (en_i) begin
         state_d = next_o;
      end
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/lfsr_stream_decrypt.sv
// Streaming LFSR decrypter: seed/tap recovery from a pad preamble,
// pad stripping, parity flagging (LFSR_PARITY_CHECK_EN) and fill.
module lfsr_stream_decrypt
   import lfsr_pkg::*;
#(
   parameter int                DATA_W   = 8,
   parameter int                NUM_PTRN = 9,
   parameter int                MSG_LEN  = 64,
   parameter int                PRE_MIN  = 10,
   parameter logic [DATA_W-1:0] PAD_CHAR = 8'h20
) (
   input  logic                         clk,
   input  logic                         init_n,
   input  logic                         req,
   output logic                         ack,
   input  logic [DATA_W-1:0]            in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(NUM_PTRN)-1:0]  ptrn_sel,
   output logic                         lock_fail,
   output logic [$clog2(MSG_LEN+1)-1:0] err_cnt
);

   localparam int LW = DATA_W - 1;
   localparam int CW = $clog2(MSG_LEN + 1);
   localparam int SW = $clog2(NUM_PTRN);
   localparam logic [LW-1:0] PAD7 = PAD_CHAR[LW-1:0];

   state_e              state_q;
   logic [NUM_PTRN-1:0] mask_q, mask_d, live;
   logic [CW-1:0]       in_cnt_q, out_cnt_q, err_cnt_q;
   logic [SW-1:0]       sel_q, first_live;
   logic [DATA_W-1:0]   out_data_q;
   logic                out_valid_q, ack_q, lock_fail_q;
   logic                in_rdy, in_xfer, out_free;
   logic                ld, en, perr, is_pad, last_in, pre_last;
   logic [LW-1:0]       st_nxt [NUM_PTRN];
   logic [LW-1:0]       seed, key, plain;

   assign out_free = !out_valid_q || out_ready;
   assign in_xfer  = in_valid && in_rdy;
   assign ld       = in_xfer && (state_q == ST_SEED);
   assign en       = in_xfer && (state_q == ST_SEARCH ||
                                 state_q == ST_STRIP  ||
                                 state_q == ST_PASS);
   assign seed     = in_data[LW-1:0] ^ PAD7;
   assign last_in  = in_cnt_q == CW'(MSG_LEN - 1);
   assign pre_last = in_cnt_q == CW'(PRE_MIN - 1);

   for (genvar k = 0; k < NUM_PTRN; k++) begin : g_cand
      lfsr_step u_step (
         .clk_i  (clk),
         .rst_ni (init_n),
         .load_i (ld),
         .en_i   (en),
         .seed_i (seed),
         .taps_i (PTRN[k]),
         .next_o (st_nxt[k])
      );
      assign live[k] = (in_data[LW-1:0] ^ st_nxt[k]) == PAD7;
   end

   assign mask_d = mask_q & live;
   assign key    = st_nxt[sel_q];
   assign plain  = in_data[LW-1:0] ^ key;

`ifdef LFSR_PARITY_CHECK_EN
   assign perr = in_data[DATA_W-1] ^ (^in_data[LW-1:0]);
`else
   logic unused_par;
   assign unused_par = in_data[DATA_W-1];
   assign perr       = 1'b0;
`endif

   assign is_pad = (plain == PAD7) && !perr;

   // Lowest-index surviving candidate wins the lock
   always_comb begin
      first_live = '0;
      for (int k = NUM_PTRN - 1; k >= 0; k--) begin
         if (mask_d[k]) first_live = SW'(k);
      end
   end

   // Input is taken only when the state can absorb a byte
   always_comb begin
      in_rdy = 1'b0;
      unique case (state_q)
         ST_SEED, ST_SEARCH: in_rdy = 1'b1;
         ST_STRIP, ST_PASS:  in_rdy = out_free;
         default:            in_rdy = 1'b0;
      endcase
   end

   // Control FSM with registered status and output byte
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state_q     <= ST_IDLE;
         mask_q      <= '1;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         err_cnt_q   <= '0;
         sel_q       <= '0;
         ack_q       <= 1'b0;
         lock_fail_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (req) begin
                  state_q     <= ST_SEED;
                  ack_q       <= 1'b0;
                  lock_fail_q <= 1'b0;
                  err_cnt_q   <= '0;
                  in_cnt_q    <= '0;
                  out_cnt_q   <= '0;
                  mask_q      <= '1;
               end
            end
            ST_SEED: begin
               if (in_xfer) begin
                  in_cnt_q <= in_cnt_q + CW'(1);
                  mask_q   <= '1;
                  state_q  <= ST_SEARCH;
               end
            end
            ST_SEARCH: begin
               if (in_xfer) begin
                  in_cnt_q <= in_cnt_q + CW'(1);
                  mask_q   <= mask_d;
                  if (pre_last) begin
                     if (mask_d == '0) begin
                        lock_fail_q <= 1'b1;
                        ack_q       <= 1'b1;
                        state_q     <= ST_DONE;
                     end else begin
                        sel_q   <= first_live;
                        state_q <= ST_STRIP;
                     end
                  end
               end
            end
            ST_STRIP, ST_PASS: begin
               if (out_valid_q && out_ready) out_valid_q <= 1'b0;
               if (in_xfer) begin
                  in_cnt_q <= in_cnt_q + CW'(1);
                  if (state_q == ST_PASS || !is_pad) begin
                     out_valid_q <= 1'b1;
                     out_data_q  <= {perr, plain};
                     out_cnt_q   <= out_cnt_q + CW'(1);
                     state_q     <= ST_PASS;
                     if (perr && err_cnt_q != {CW{1'b1}}) begin
                        err_cnt_q <= err_cnt_q + CW'(1);
                     end
                  end
                  if (last_in) state_q <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (out_free) begin
                  if (out_cnt_q != CW'(MSG_LEN)) begin
                     out_valid_q <= 1'b1;
                     out_data_q  <= {1'b0, PAD7};
                     out_cnt_q   <= out_cnt_q + CW'(1);
                  end else begin
                     out_valid_q <= 1'b0;
                     ack_q       <= 1'b1;
                     state_q     <= ST_DONE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ack       = ack_q;
   assign in_ready  = in_rdy;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign ptrn_sel  = sel_q;
   assign lock_fail = lock_fail_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_lfsr_stream_decrypt.sv
// Randomized bench for lfsr_stream_decrypt against a queue-based model
// that encrypts plaintext and decodes it straight from the stream rules.
module tb_lfsr_stream_decrypt;

   localparam int MSG = 64;
   localparam int PRE = 10;
`ifdef LFSR_PARITY_CHECK_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam logic [6:0] PT [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                     7'h69, 7'h5C, 7'h7E, 7'h7B};

   logic       clk, init_n, req, ack;
   logic [7:0] in_data, out_data;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [3:0] ptrn_sel;
   logic       lock_fail;
   logic [6:0] err_cnt;

   lfsr_stream_decrypt #(
      .DATA_W(8), .NUM_PTRN(9), .MSG_LEN(MSG),
      .PRE_MIN(PRE), .PAD_CHAR(8'h20)
   ) dut (
      .clk(clk), .init_n(init_n), .req(req), .ack(ack),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .ptrn_sel(ptrn_sel), .lock_fail(lock_fail), .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] stim [MSG];
   logic [6:0] msgq [$];
   logic [7:0] exp_q [$];
   logic [7:0] got [$];
   int e_sel, e_err, consumed, hold_bad;
   bit e_fail, aborted;
   int n_run = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] want);
      n_run++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, want);
      end
   endtask

   function automatic logic [6:0] stp(input logic [6:0] s,
                                      input logic [6:0] t);
      int fb;
      fb = $countones(s & t) % 2;
      return 7'((int'(s) * 2 + fb) % 128);
   endfunction

   task automatic set_msg(input string s, input int lead);
      byte b;
      msgq.delete();
      repeat (lead) msgq.push_back(7'h20);
      for (int i = 0; i < s.len(); i++) begin
         b = s[i];
         msgq.push_back(b[6:0]);
      end
   endtask

   task automatic rand_msg(input int lead, input int n);
      msgq.delete();
      repeat (lead) msgq.push_back(7'h20);
      repeat (n) msgq.push_back(7'($urandom_range(33, 126)));
   endtask

   // Plaintext = pre pads, message, trailing pads; byte j keyed by state j
   task automatic build(input int p, input logic [6:0] seed, input int pre);
      logic [6:0] s, pl, c;
      s = seed;
      for (int j = 0; j < MSG; j++) begin
         if (j >= pre && j - pre < msgq.size()) pl = msgq[j-pre];
         else pl = 7'h20;
         c = pl ^ s;
         stim[j] = {^c, c};
         s = stp(s, PT[p]);
      end
   endtask

   task automatic model();
      logic [6:0] seed, s, p;
      bit ok, started, e;
      seed = stim[0][6:0] ^ 7'h20;
      e_sel = -1;
      for (int k = 0; k < 9; k++) begin
         s = seed;
         ok = 1'b1;
         for (int j = 1; j < PRE; j++) begin
            s = stp(s, PT[k]);
            if ((stim[j][6:0] ^ s) != 7'h20) ok = 1'b0;
         end
         if (ok && e_sel < 0) e_sel = k;
      end
      e_fail = (e_sel < 0);
      e_err = 0;
      exp_q.delete();
      if (!e_fail) begin
         s = seed;
         for (int j = 1; j < PRE; j++) s = stp(s, PT[e_sel]);
         started = 1'b0;
         for (int j = PRE; j < MSG; j++) begin
            s = stp(s, PT[e_sel]);
            p = stim[j][6:0] ^ s;
            e = PAR && (stim[j][7] != (^stim[j][6:0]));
            if (started || p != 7'h20 || e) begin
               started = 1'b1;
               exp_q.push_back({e, p});
               e_err += int'(e);
            end
         end
         while (exp_q.size() < MSG) exp_q.push_back(8'h20);
      end
   endtask

   task automatic run(input bit stall, input int abort_at);
      int cyc;
      logic [7:0] held;
      bit hold_v;
      got.delete();
      consumed = 0;
      hold_bad = 0;
      hold_v = 1'b0;
      held = '0;
      aborted = 1'b0;
      cyc = 0;
      @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      while (cyc < 2000 && !ack) begin
         in_valid = (consumed < MSG) && (!stall || $urandom_range(0, 2) != 0);
         if (in_valid) in_data = stim[consumed];
         else in_data = 8'($urandom);
         out_ready = !stall || ($urandom_range(0, 2) == 0);
         #1;
         if (hold_v && (!out_valid || out_data !== held)) hold_bad++;
         hold_v = out_valid && !out_ready;
         held = out_data;
         if (in_valid && in_ready) consumed++;
         if (out_valid && out_ready) got.push_back(out_data);
         if (abort_at > 0 && got.size() >= abort_at) begin
            #2 init_n = 1'b0;
            #1;
            check("arst_ov", 32'(out_valid), 0);
            check("arst_od", 32'(out_data), 0);
            check("arst_ack", 32'(ack), 0);
            check("arst_sel", 32'(ptrn_sel), 0);
            check("arst_err", 32'(err_cnt), 0);
            check("arst_rdy", 32'(in_ready), 0);
            aborted = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic check_run(input string tag);
      check({tag, "_ack"}, 32'(ack), 1);
      check({tag, "_fail"}, 32'(lock_fail), 32'(e_fail));
      check({tag, "_err"}, 32'(err_cnt), e_err);
      check({tag, "_cnt"}, got.size(), exp_q.size());
      check({tag, "_hold"}, hold_bad, 0);
      if (e_fail) check({tag, "_used"}, consumed, PRE);
      else check({tag, "_sel"}, 32'(ptrn_sel), e_sel);
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p, pre, lead, n, pos;
      init_n = 1'b0;
      req = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(ack), 0);
      check("rst_ov", 32'(out_valid), 0);
      check("rst_od", 32'(out_data), 0);
      check("rst_sel", 32'(ptrn_sel), 0);
      check("rst_lf", 32'(lock_fail), 0);
      check("rst_err", 32'(err_cnt), 0);
      check("rst_rdy", 32'(in_ready), 0);
      init_n = 1'b1;
      @(negedge clk);

      set_msg("four score", 0);
      build(0, 7'h01, 10);
      model();
      run(1'b0, 0);
      check_run("lock");
      check("lock_sel_lit", 32'(ptrn_sel), 0);
      check("lock_err_lit", 32'(err_cnt), 0);
      if (got.size() > 10) begin
         check("lock_b0_lit", 32'(got[0]), 32'h66);
         check("lock_b10_lit", 32'(got[10]), 32'h20);
      end

      for (int k = 0; k < 9; k++) begin
         set_msg("four score and seven", 4);
         build(k, 7'h7F, 26);
         model();
         run(1'b0, 0);
         check_run($sformatf("sweep%0d", k));
      end

      set_msg("four score and seven years ago our fathers", 0);
      build(3, 7'h2B, 10);
      stim[30] ^= 8'h08;
      stim[40] ^= 8'h08;
      model();
      run(1'b0, 0);
      check_run("corrupt");
      check("corrupt_err_lit", 32'(err_cnt), PAR ? 2 : 0);

      set_msg("", 0);
      build(5, 7'h11, 10);
      model();
      run(1'b0, 0);
      check_run("allpad");

      rand_msg(0, 54);
      build(7, 7'h45, 10);
      model();
      run(1'b1, 0);
      check_run("full");

      for (int r = 0; r < 4; r++) begin
         p = $urandom_range(0, 8);
         pre = $urandom_range(10, 20);
         lead = $urandom_range(0, 5);
         n = $urandom_range(10, 30);
         rand_msg(lead, n);
         build(p, 7'($urandom_range(1, 127)), pre);
         repeat (r % 3) begin
            pos = $urandom_range(pre, MSG - 1);
            stim[pos] ^= 8'(1 << $urandom_range(0, 7));
         end
         model();
         run(1'b0, 0);
         check_run($sformatf("rnd%0d", r));
         run(1'b1, 0);
         check_run($sformatf("stall%0d", r));
      end

      rand_msg(0, 40);
      build(2, 7'h5A, 12);
      model();
      run(1'b0, 5);
      @(negedge clk);
      init_n = 1'b1;
      @(negedge clk);
      run(1'b1, 0);
      check_run("after_rst");

      set_msg("four score", 0);
      build(4, 7'h33, 10);
      stim[5] ^= 8'h08;
      model();
      run(1'b0, 0);
      check_run("lockfail");
      check("lockfail_lit", 32'(lock_fail), 1);
      check("lockfail_n", got.size(), 0);

      set_msg("four score", 2);
      build(6, 7'h19, 12);
      model();
      run(1'b0, 0);
      check_run("rerun");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
